// File: rtl/txpause.sv
// rtl/txpause.sv - 802.3x PAUSE frame inserter on the 64-bit TX stream, ahead of the CRC framer.
// Optional feature macro: TXPAUSE_XON_EN (release of pause_req emits a quanta-0 frame).
module txpause #(
  parameter int TIMER_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   cfg_tx_pause_enable,
  input  logic [15:0]            cfg_pause_quanta,
  input  logic [TIMER_WIDTH-1:0] cfg_refresh_quanta,
  input  logic [7:0]             cfg_sub_quanta_count,
  input  logic [47:0]            cfg_src_mac,
  input  logic                   pause_req,
  input  logic [63:0]            tdata_i,
  input  logic [7:0]             tkeep_i,
  input  logic                   tvalid_i,
  input  logic                   tlast_i,
  output logic                   tready_o,
  output logic [63:0]            tdata_o,
  output logic [7:0]             tkeep_o,
  output logic                   tvalid_o,
  output logic                   tlast_o,
  input  logic                   tready_i,
  output logic                   pause_tx_busy
);

  typedef enum logic [1:0] {s_idle, s_user, s_pause} state_t;

  state_t                 state, state_nxt;
  logic [2:0]             beat;
  logic                   req_d;
  logic                   pending;
  logic [15:0]            quanta_q;
  logic [TIMER_WIDTH-1:0] timer;
  logic [7:0]             presc;
  logic                   rise, fall, tick, expiry, trigger;
  logic                   beat_acc, beat0_acc, last_acc;

  assign rise = pause_req & ~req_d;
`ifdef TXPAUSE_XON_EN
  assign fall = ~pause_req & req_d;
`else
  assign fall = 1'b0;
`endif

  assign tick      = (cfg_sub_quanta_count <= 8'd1) || (presc >= cfg_sub_quanta_count - 8'd1);
  assign expiry    = pause_req && (timer == TIMER_WIDTH'(1)) && tick;
  assign trigger   = rise | fall | expiry;
  assign beat_acc  = (state == s_pause) && tready_i;
  assign beat0_acc = beat_acc && (beat == 3'd0);
  assign last_acc  = beat_acc && (beat == 3'd7);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= s_idle;
      beat     <= 3'd0;
      req_d    <= 1'b0;
      pending  <= 1'b0;
      quanta_q <= 16'd0;
    end else begin
      state <= state_nxt;
      req_d <= pause_req;
      if (state != s_pause)
        beat <= 3'd0;
      else if (tready_i)
        beat <= beat + 3'd1;
      // New triggers win over the beat-0 clear so an event is never lost.
      if (!cfg_tx_pause_enable)
        pending <= 1'b0;
      else if (trigger)
        pending <= 1'b1;
      else if (beat0_acc)
        pending <= 1'b0;
      // Quanta is frozen as beat 2 comes up so it stays stable under backpressure.
      if (beat_acc && beat == 3'd1)
        quanta_q <= pause_req ? cfg_pause_quanta : 16'd0;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      timer <= '0;
      presc <= 8'd0;
    end else if (!cfg_tx_pause_enable || !pause_req) begin
      timer <= '0;
      presc <= 8'd0;
    end else if (last_acc && quanta_q != 16'd0) begin
      // The beat-7 accept cycle counts as the first sub-quanta cycle,
      // so the idle gap before the refresh frame is refresh * sub cycles.
      timer <= cfg_refresh_quanta;
      presc <= 8'd1;
    end else if (timer != '0) begin
      if (tick) begin
        presc <= 8'd0;
        timer <= timer - TIMER_WIDTH'(1);
      end else begin
        presc <= presc + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    tready_o      = 1'b0;
    tdata_o       = 64'd0;
    tkeep_o       = 8'd0;
    tvalid_o      = 1'b0;
    tlast_o       = 1'b0;
    pause_tx_busy = 1'b0;
    case (state)
      s_idle: begin
        if (pending) begin
          state_nxt = s_pause;
        end else if (tvalid_i && tready_i && !tlast_i) begin
          state_nxt = s_user;
        end
      end
      s_user: begin
        if (tvalid_i && tready_i && tlast_i)
          state_nxt = pending ? s_pause : s_idle;
      end
      s_pause: begin
        if (tready_i && beat == 3'd7)
          state_nxt = s_idle;
      end
      default: state_nxt = s_idle;
    endcase
    if (aresetn) begin
      if (state == s_pause) begin
        pause_tx_busy = 1'b1;
        tvalid_o      = 1'b1;
        tlast_o       = (beat == 3'd7);
        tkeep_o       = (beat == 3'd7) ? 8'h0F : 8'hFF;
        case (beat)
          3'd0:    tdata_o = {cfg_src_mac[15:0], 48'h010000C28001};
          3'd1:    tdata_o = {32'h01000888, cfg_src_mac[47:16]};
          3'd2:    tdata_o = {48'd0, quanta_q[7:0], quanta_q[15:8]};
          default: tdata_o = 64'd0;
        endcase
      end else if (!(state == s_idle && pending)) begin
        tready_o = tready_i;
        tdata_o  = tdata_i;
        tkeep_o  = tkeep_i;
        tvalid_o = tvalid_i;
        tlast_o  = tlast_i;
      end
    end
  end

endmodule

// File: tb/tb_txpause.sv
// tb/tb_txpause.sv - self-checking bench for txpause: vector table, scoreboard and PAUSE corner sequences.
module tb_txpause;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        cfg_tx_pause_enable;
  logic [15:0] cfg_pause_quanta;
  logic [15:0] cfg_refresh_quanta;
  logic [7:0]  cfg_sub_quanta_count;
  logic [47:0] cfg_src_mac;
  logic        pause_req;
  logic [63:0] tdata_i;
  logic [7:0]  tkeep_i;
  logic        tvalid_i;
  logic        tlast_i;
  logic        tready_o;
  logic [63:0] tdata_o;
  logic [7:0]  tkeep_o;
  logic        tvalid_o;
  logic        tlast_o;
  logic        tready_i;
  logic        pause_tx_busy;

  txpause #(.TIMER_WIDTH(16)) dut (
    .clk(clk), .aresetn(aresetn), .cfg_tx_pause_enable(cfg_tx_pause_enable),
    .cfg_pause_quanta(cfg_pause_quanta), .cfg_refresh_quanta(cfg_refresh_quanta),
    .cfg_sub_quanta_count(cfg_sub_quanta_count), .cfg_src_mac(cfg_src_mac),
    .pause_req(pause_req), .tdata_i(tdata_i), .tkeep_i(tkeep_i), .tvalid_i(tvalid_i),
    .tlast_i(tlast_i), .tready_o(tready_o), .tdata_o(tdata_o), .tkeep_o(tkeep_o),
    .tvalid_o(tvalid_o), .tlast_o(tlast_o), .tready_i(tready_i), .pause_tx_busy(pause_tx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  typedef struct {
    logic        v;
    logic        r;
    logic        l;
    logic [63:0] d;
    logic        exp_v;
    logic        exp_r;
  } vec_t;

  beat_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t pause_beat(input int b, input logic [15:0] q, input logic [47:0] sa);
    logic [7:0] by [0:63];
    beat_t r;
    for (int i = 0; i < 64; i++) by[i] = 8'h00;
    by[0] = 8'h01; by[1] = 8'h80; by[2] = 8'hC2; by[5] = 8'h01;
    for (int i = 0; i < 6; i++) by[6+i] = sa[8*i +: 8];
    by[12] = 8'h88; by[13] = 8'h08; by[14] = 8'h00; by[15] = 8'h01;
    by[16] = q[15:8]; by[17] = q[7:0];
    for (int n = 0; n < 8; n++) r.d[8*n +: 8] = by[8*b + n];
    r.k = (b == 7) ? 8'h0F : 8'hFF;
    r.l = (b == 7);
    return r;
  endfunction

  task automatic push_pause(input logic [15:0] q);
    for (int b = 0; b < 8; b++) sb.push_back(pause_beat(b, q, cfg_src_mac));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((sb.size() != 0 || pause_tx_busy) && t < 300) begin
      cyc();
      t++;
    end
    chk({name, "_drained"}, 80'(sb.size()), 80'd0);
    repeat (12) cyc();
    chk({name, "_idle_busy"}, 80'(pause_tx_busy), 80'd0);
  endtask

  // Scoreboard monitor plus stability check for stalled PAUSE beats.
  logic        hold = 1'b0;
  logic [63:0] hold_d;
  always @(negedge clk) begin
    beat_t e;
    if (aresetn) begin
      if (hold) chk("stall_stable", {15'd0, tvalid_o, tdata_o}, {15'd0, 1'b1, hold_d});
      hold   = tvalid_o && !tready_i && pause_tx_busy;
      hold_d = tdata_o;
      if (tvalid_o && tready_i) begin
        chk("beat_expected", 80'(sb.size() != 0), 80'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("beat", {7'd0, tlast_o, tkeep_o, tdata_o}, {7'd0, e.l, e.k, e.d});
        end
      end
    end else begin
      hold = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [9];
    int lat, gap, acc, t;

    aresetn = 1'b0; cfg_tx_pause_enable = 1'b1; cfg_pause_quanta = 16'hFFFF;
    cfg_refresh_quanta = 16'd0; cfg_sub_quanta_count = 8'd8; cfg_src_mac = 48'h665544332211;
    pause_req = 1'b0; tdata_i = 64'hDEAD_BEEF_0123_4567; tkeep_i = 8'hFF;
    tvalid_i = 1'b1; tlast_i = 1'b1; tready_i = 1'b1;
    repeat (3) cyc();
    chk("rst_tvalid", 80'(tvalid_o), 80'd0);
    chk("rst_tready", 80'(tready_o), 80'd0);
    chk("rst_tdata", 80'(tdata_o), 80'd0);
    chk("rst_tkeep", 80'(tkeep_o), 80'd0);
    chk("rst_tlast", 80'(tlast_o), 80'd0);
    chk("rst_busy", 80'(pause_tx_busy), 80'd0);
    tvalid_i = 1'b0; tlast_i = 1'b0;
    cyc();
    aresetn = 1'b1;
    cyc();

    // Pass-through vectors: {valid, ready, last, data, exp tvalid_o, exp tready_o}
    vt[0] = '{1'b1, 1'b1, 1'b0, 64'h1111_0000_0000_0001, 1'b1, 1'b1};
    vt[1] = '{1'b1, 1'b0, 1'b0, 64'h2222_0000_0000_0002, 1'b1, 1'b0};
    vt[2] = '{1'b1, 1'b1, 1'b0, 64'h2222_0000_0000_0002, 1'b1, 1'b1};
    vt[3] = '{1'b0, 1'b1, 1'b0, 64'h0,                   1'b0, 1'b1};
    vt[4] = '{1'b1, 1'b1, 1'b1, 64'h3333_0000_0000_0003, 1'b1, 1'b1};
    vt[5] = '{1'b1, 1'b1, 1'b1, 64'h4444_0000_0000_0004, 1'b1, 1'b1};
    vt[6] = '{1'b0, 1'b0, 1'b0, 64'h0,                   1'b0, 1'b0};
    vt[7] = '{1'b1, 1'b1, 1'b0, 64'h5555_0000_0000_0005, 1'b1, 1'b1};
    vt[8] = '{1'b1, 1'b1, 1'b1, 64'h6666_0000_0000_0006, 1'b1, 1'b1};
    for (int i = 0; i < 9; i++) begin
      tvalid_i = vt[i].v; tready_i = vt[i].r; tlast_i = vt[i].l; tdata_i = vt[i].d;
      if (vt[i].v && vt[i].r) sb.push_back('{vt[i].d, 8'hFF, vt[i].l});
      #1;
      chk("pass_tready", 80'(tready_o), 80'(vt[i].exp_r));
      chk("pass_tvalid", 80'(tvalid_o), 80'(vt[i].exp_v));
      cyc();
    end
    tvalid_i = 1'b0; tlast_i = 1'b0; tready_i = 1'b1;
    drain("user");

    // XOFF from an idle link
    pause_req = 1'b1;
    push_pause(16'hFFFF);
    lat = 0;
    while (!tvalid_o && lat < 10) begin
      cyc();
      lat++;
    end
    chk("xoff_latency", 80'(lat), 80'd2);
    chk("beat0_da", 80'(tdata_o[47:0]), 80'(48'h010000C28001));
    for (int i = 0; i < 8; i++) begin
      chk("xoff_busy", 80'(pause_tx_busy), 80'd1);
      chk("xoff_tready", 80'(tready_o), 80'd0);
      cyc();
    end
    chk("xoff_busy_end", 80'(pause_tx_busy), 80'd0);
    pause_req = 1'b0;
`ifdef TXPAUSE_XON_EN
    push_pause(16'h0000);
`endif
    drain("release1");

    // Trigger in the middle of a 10-beat user packet
    for (int i = 0; i < 10; i++) begin
      tvalid_i = 1'b1; tdata_i = 64'hA000 + 64'(i); tlast_i = (i == 9);
      if (i == 3) pause_req = 1'b1;
      sb.push_back('{tdata_i, 8'hFF, tlast_i});
      #1;
      chk("pkt_tready", 80'(tready_o), 80'd1);
      cyc();
    end
    tvalid_i = 1'b0; tlast_i = 1'b0;
    push_pause(16'hFFFF);
    for (int i = 0; i < 8; i++) begin
      chk("mid_tvalid", 80'(tvalid_o), 80'd1);
      chk("mid_tready", 80'(tready_o), 80'd0);
      cyc();
    end
    pause_req = 1'b0;
`ifdef TXPAUSE_XON_EN
    push_pause(16'h0000);
`endif
    drain("release2");

    // Refresh: 4 quanta x 8 cycles; release during the refresh frame makes its quanta 0
    cfg_refresh_quanta = 16'd4;
    pause_req = 1'b1;
    push_pause(16'hFFFF);
    push_pause(16'h0000);
    t = 0;
    while (!(tvalid_o && tlast_o && tready_i) && t < 40) begin
      cyc();
      t++;
    end
    chk("refresh_first_end", 80'(tlast_o), 80'd1);
    cyc();
    gap = 0;
    while (!tvalid_o && gap < 100) begin
      gap++;
      cyc();
    end
    chk("refresh_gap", 80'(gap), 80'd32);
    cyc();
    pause_req = 1'b0;
`ifdef TXPAUSE_XON_EN
    push_pause(16'h0000);
`endif
    drain("refresh");
    cfg_refresh_quanta = 16'd0;

    // Backpressure toggling every cycle during a frame
    pause_req = 1'b1;
    push_pause(16'hFFFF);
    for (int i = 0; i < 40; i++) begin
      tready_i = ~tready_i;
      cyc();
    end
    tready_i = 1'b1;
    pause_req = 1'b0;
`ifdef TXPAUSE_XON_EN
    push_pause(16'h0000);
`endif
    drain("toggle");

    // Disabled: edges are ignored
    cfg_tx_pause_enable = 1'b0;
    pause_req = 1'b1;
    repeat (15) cyc();
    cfg_tx_pause_enable = 1'b1;
    repeat (15) cyc();
    chk("disabled_busy", 80'(pause_tx_busy), 80'd0);
    pause_req = 1'b0;
`ifdef TXPAUSE_XON_EN
    push_pause(16'h0000);
`endif
    drain("disable");

    // Reset asserted while beat 4 is on the bus
    pause_req = 1'b1;
    push_pause(16'hFFFF);
    acc = 0; t = 0;
    while (!(pause_tx_busy && acc == 4) && t < 40) begin
      if (pause_tx_busy && tready_i) acc++;
      cyc();
      t++;
    end
    chk("rst_mid_beat", 80'(acc), 80'd4);
    #1;
    aresetn = 1'b0;
    #1;
    chk("rst_mid_tvalid", 80'(tvalid_o), 80'd0);
    chk("rst_mid_busy", 80'(pause_tx_busy), 80'd0);
    sb.delete();
    pause_req = 1'b0;
    repeat (2) cyc();
    aresetn = 1'b1;
    drain("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
